// File: rtl/rotary_encoder_if.sv
// rotary_encoder_if: front-panel encoder lines and the read-and-clear register toward spi_Interface
interface rotary_encoder_if;
  logic       encoder_A;
  logic       encoder_B;
  logic       encoder_sw;
  logic       rotary_encoder_rd_stb;
  logic [7:0] rotary_encoder_reg;
  logic       sw_level;
  logic [15:0] test;
  modport master (
    output encoder_A, encoder_B, encoder_sw, rotary_encoder_rd_stb,
    input  rotary_encoder_reg, sw_level, test
  );
  modport slave (
    input  encoder_A, encoder_B, encoder_sw, rotary_encoder_rd_stb,
    output rotary_encoder_reg, sw_level, test
  );
endinterface

// File: rtl/rotary_encoder_decoder.sv
// rotary_encoder_decoder: synchronizes, debounces and quadrature-decodes a rotary encoder into a read-and-clear register
module rotary_encoder_decoder #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int DB_CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  rotary_encoder_if.slave bus
);
  localparam logic [DB_CNT_W-1:0] DB_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [2:0]          r_sync1, r_sync2, r_db, r_db_prev;
  logic [DB_CNT_W-1:0] r_cnt [3];
  logic [2:0]          r_acc;
  logic [6:0]          r_count;
  logic                r_flag, r_live;
  logic [1:0]          w_ab, w_ab_prev;
  logic                w_moved, w_illegal, w_cw, w_detent, w_up, w_dn, w_press, w_rd;
  logic [3:0]          w_sum, w_step;
  logic [6:0]          w_base, w_count_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= {bus.encoder_A, bus.encoder_B, bus.encoder_sw};
      r_sync2 <= r_sync1;
    end
  end
  // The counter measures how long the synchronized level has disagreed with the accepted level.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        r_db[k]  <= 1'b1;
        r_cnt[k] <= '0;
      end else if (r_sync2[k] == r_db[k]) begin
        r_cnt[k] <= '0;
      end else if (r_cnt[k] == DB_MAX) begin
        r_db[k]  <= r_sync2[k];
        r_cnt[k] <= '0;
      end else begin
        r_cnt[k] <= r_cnt[k] + DB_CNT_W'(1);
      end
    end
  end
  always_comb begin
    w_ab      = r_db[2:1];
    w_ab_prev = r_db_prev[2:1];
    w_moved   = w_ab != w_ab_prev;
    w_illegal = &(w_ab ^ w_ab_prev);
    w_cw      = w_ab == {~w_ab_prev[0], w_ab_prev[1]};
    w_sum     = {r_acc[2], r_acc} + (w_cw ? 4'h1 : 4'hF);
    w_step    = (w_sum == 4'hB) ? 4'hC : w_sum;
    w_detent  = w_moved & ~w_illegal & (w_ab == 2'b11);
    w_up      = w_detent & (w_step == 4'h4);
    w_dn      = w_detent & (w_step == 4'hC);
    w_press   = r_db_prev[0] & ~r_db[0];
    w_rd      = bus.rotary_encoder_rd_stb;
    w_base    = w_rd ? 7'h00 : r_count;
    w_count_next = (w_up && w_base != 7'h3F) ? w_base + 7'h01 :
                   (w_dn && w_base != 7'h40) ? w_base - 7'h01 : w_base;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_prev <= 3'b111;
      r_acc     <= 3'b000;
      r_count   <= 7'h00;
      r_flag    <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_db_prev <= r_db;
      r_acc     <= !w_moved ? r_acc : (w_illegal | w_detent) ? 3'b000 : w_step[2:0];
      r_count   <= w_count_next;
      r_flag    <= w_press | (r_flag & ~w_rd);
      r_live    <= 1'b1;
    end
  end
  assign bus.rotary_encoder_reg = {r_flag, r_count};
  assign bus.sw_level           = ~r_db[0];
  assign bus.test               = r_live ? {r_acc, r_db, r_sync2[2:1], r_flag, r_count} : 16'h0000;
endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// tb_rotary_encoder_decoder: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_rotary_encoder_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rotary_encoder_if bus();
  rotary_encoder_decoder #(.DEBOUNCE_CYCLES(4), .DB_CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_push(input string name, input int kind, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask
  task automatic exp_reg(input string name, input logic [7:0] v);
    exp_push(name, 0, {8'h00, v});
  endtask
  task automatic set_ab(input logic a, input logic b);
    bus.encoder_A = a;
    bus.encoder_B = b;
    tick(10);
  endtask
  task automatic cw();
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
  endtask
  task automatic ccw();
    set_ab(1'b1, 1'b0); set_ab(1'b0, 1'b0); set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1);
  endtask
  task automatic rd();
    bus.rotary_encoder_rd_stb = 1'b1;
    tick(1);
    bus.rotary_encoder_rd_stb = 1'b0;
  endtask
  initial begin : monitor
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = (e.kind == 0) ? {8'h00, bus.rotary_encoder_reg} :
              (e.kind == 1) ? {15'h0000, bus.sw_level} : bus.test;
        n_chk++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    bus.encoder_A = 1'b1;
    bus.encoder_B = 1'b1;
    bus.encoder_sw = 1'b1;
    bus.rotary_encoder_rd_stb = 1'b0;
    tick(3);
    exp_reg("reset_reg", 8'h00);
    exp_push("reset_sw", 1, 16'h0000);
    exp_push("reset_test", 2, 16'h0000);
    reset = 1'b0;
    tick(2);
    exp_push("idle_test", 2, 16'h1F00);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0);
    exp_push("acc3_test", 2, 16'h7600);
    set_ab(1'b1, 1'b1);
    exp_reg("cw1", 8'h01);
    repeat (3) ccw();
    exp_reg("ccw3", 8'h7E);
    rd();
    exp_reg("clr1", 8'h00);
    bus.encoder_A = 1'b0; tick(1); bus.encoder_A = 1'b1; tick(10);
    bus.encoder_B = 1'b0; tick(3); bus.encoder_B = 1'b1; tick(10);
    exp_reg("glitch_reg", 8'h00);
    exp_push("glitch_test", 2, 16'h1F00);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1);
    exp_reg("half_turn", 8'h00);
    repeat (70) cw();
    exp_reg("sat_pos", 8'h3F);
    ccw();
    exp_reg("sat_back", 8'h3E);
    rd();
    exp_reg("clr2", 8'h00);
    bus.encoder_sw = 1'b0; tick(10);
    exp_reg("press_flag", 8'h80);
    exp_push("sw_down", 1, 16'h0001);
    bus.encoder_sw = 1'b1; tick(10);
    exp_reg("release_keeps", 8'h80);
    exp_push("sw_up", 1, 16'h0000);
    rd();
    exp_reg("rd_clr", 8'h00);
    rd();
    exp_reg("rd_again", 8'h00);
    repeat (5) cw();
    exp_reg("five", 8'h05);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0);
    bus.encoder_A = 1'b1; bus.encoder_B = 1'b1; tick(6);
    rd();
    exp_reg("rd_detent_cw", 8'h01);
    tick(5);
    bus.encoder_sw = 1'b0; tick(6);
    rd();
    exp_reg("rd_press", 8'h80);
    bus.encoder_sw = 1'b1; tick(10);
    rd();
    exp_reg("clr3", 8'h00);
    set_ab(1'b1, 1'b0); set_ab(1'b0, 1'b0); set_ab(1'b0, 1'b1);
    bus.encoder_A = 1'b1; bus.encoder_B = 1'b1; tick(6);
    rd();
    exp_reg("rd_detent_ccw", 8'h7F);
    tick(5);
    rd();
    exp_reg("clr4", 8'h00);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0);
    reset = 1'b1; tick(2); reset = 1'b0; tick(10);
    set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
    exp_reg("reset_mid", 8'h00);
    set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
    exp_reg("illegal_jump", 8'h00);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
    exp_reg("illegal_mid", 8'h00);
    cw();
    exp_reg("after_illegal", 8'h01);
    tick(3);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
